// File: rtl/cdc_pkg.sv
// Shared helpers for the clock-domain-crossing blocks: Gray/binary conversion and chain limits.
package cdc_pkg;

  localparam int MIN_CHAIN_LENGTH = 2;
  localparam int GRAY_MAX_W = 32;

  // Operands narrower than GRAY_MAX_W are zero-extended by the caller and truncated back.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/cdc_gray_sync.sv
// WIDTH-bit, CHAIN_LENGTH-deep synchronizer chain for Gray-coded pointers.
module cdc_gray_sync
  import cdc_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CHAIN_LENGTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (CHAIN_LENGTH < MIN_CHAIN_LENGTH) begin : g_chain_check
    $error("cdc_gray_sync: CHAIN_LENGTH below minimum");
  end

  logic [WIDTH-1:0] chain_q [CHAIN_LENGTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < CHAIN_LENGTH; i++) chain_q[i] <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < CHAIN_LENGTH; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q_o = chain_q[CHAIN_LENGTH-1];

endmodule

// File: rtl/cdc_async_fifo.sv
// First-word-fall-through async FIFO, clk_src -> clk_dest, Gray pointers crossing via cdc_gray_sync.
// Define CDC_ASYNC_FIFO_LEVEL_EN to add src_level_o/dest_level_o and the one-sided-reset assertion.
module cdc_async_fifo
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 3,
  parameter int CHAIN_LENGTH = 3
) (
  input  logic                  clk_src,
  input  logic                  reset_master_src_n,
  input  logic                  clk_dest,
  input  logic                  reset_master_dest_n,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i
`ifdef CDC_ASYNC_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   src_level_o,
  output logic [ADDR_WIDTH:0]   dest_level_o
`endif
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Full compares against the read pointer with its two Gray MSBs flipped.
  localparam logic [PW-1:0] GRAY_FULL_MASK = PW'(3) << (PW - 2);

  if (ADDR_WIDTH < 1 || PW > GRAY_MAX_W) begin : g_addr_check
    $error("cdc_async_fifo: ADDR_WIDTH out of range");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wptr_bin_q, wptr_bin_d, wptr_gray_q, wptr_gray_d, rptr_gray_sync;
  logic [PW-1:0] rptr_bin_q, rptr_bin_d, rptr_gray_q, rptr_gray_d, wptr_gray_sync;
  logic          ready_q, valid_q, wr_en, rd_en, full_next, empty_next;

  // ---------------- source domain ----------------
  assign wr_en = valid_i & ready_q;

  always_comb begin
    wptr_bin_d  = wptr_bin_q + PW'(wr_en);
    wptr_gray_d = PW'(bin2gray(GRAY_MAX_W'(wptr_bin_d)));
    full_next   = (wptr_gray_d == (rptr_gray_sync ^ GRAY_FULL_MASK));
  end

  always_ff @(posedge clk_src or negedge reset_master_src_n) begin
    if (!reset_master_src_n) begin
      wptr_bin_q  <= '0;
      wptr_gray_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      wptr_bin_q  <= wptr_bin_d;
      wptr_gray_q <= wptr_gray_d;
      ready_q     <= ~full_next;
    end
  end

  always_ff @(posedge clk_src) begin
    if (wr_en) mem_q[wptr_bin_q[ADDR_WIDTH-1:0]] <= data_i;
  end

  cdc_gray_sync #(.WIDTH(PW), .CHAIN_LENGTH(CHAIN_LENGTH)) u_sync_rptr (
    .clk_i (clk_src),
    .rst_ni(reset_master_src_n),
    .d_i   (rptr_gray_q),
    .q_o   (rptr_gray_sync)
  );

  // ---------------- destination domain ----------------
  assign rd_en = valid_q & ready_i;

  always_comb begin
    rptr_bin_d  = rptr_bin_q + PW'(rd_en);
    rptr_gray_d = PW'(bin2gray(GRAY_MAX_W'(rptr_bin_d)));
    empty_next  = (rptr_gray_d == wptr_gray_sync);
  end

  always_ff @(posedge clk_dest or negedge reset_master_dest_n) begin
    if (!reset_master_dest_n) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= rptr_gray_d;
      valid_q     <= ~empty_next;
    end
  end

  cdc_gray_sync #(.WIDTH(PW), .CHAIN_LENGTH(CHAIN_LENGTH)) u_sync_wptr (
    .clk_i (clk_dest),
    .rst_ni(reset_master_dest_n),
    .d_i   (wptr_gray_q),
    .q_o   (wptr_gray_sync)
  );

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = mem_q[rptr_bin_q[ADDR_WIDTH-1:0]];

`ifdef CDC_ASYNC_FIFO_LEVEL_EN
  logic [PW-1:0] rptr_bin_sync, wptr_bin_sync, src_level_q, dest_level_q;

  assign rptr_bin_sync = PW'(gray2bin(GRAY_MAX_W'(rptr_gray_sync)));
  assign wptr_bin_sync = PW'(gray2bin(GRAY_MAX_W'(wptr_gray_sync)));

  // Stale remote pointers make src over- and dest under-estimate, never past DEPTH.
  always_ff @(posedge clk_src or negedge reset_master_src_n) begin
    if (!reset_master_src_n) src_level_q <= '0;
    else                     src_level_q <= wptr_bin_d - rptr_bin_sync;
  end

  always_ff @(posedge clk_dest or negedge reset_master_dest_n) begin
    if (!reset_master_dest_n) dest_level_q <= '0;
    else                      dest_level_q <= wptr_bin_sync - rptr_bin_d;
  end

  assign src_level_o  = src_level_q;
  assign dest_level_o = dest_level_q;

  a_src_reset_shared: assert property (@(posedge clk_src)
    $fell(reset_master_src_n) |-> !reset_master_dest_n);
  a_dest_reset_shared: assert property (@(posedge clk_dest)
    $fell(reset_master_dest_n) |-> !reset_master_src_n);
`endif

endmodule

// File: tb/tb_cdc_async_fifo.sv
// Randomized bench for cdc_async_fifo against a queue-based reference of the word stream.
`timescale 1ns/1ps
module tb_cdc_async_fifo;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int CL    = 3;
  localparam int DEPTH = 1 << AW;

  logic clk_src = 1'b0;
  logic clk_dest = 1'b0;
  int   src_half = 5;
  int   dest_half = 32;

  always #(src_half) clk_src = ~clk_src;
  always #(dest_half) clk_dest = ~clk_dest;

  logic          reset_master_src_n, reset_master_dest_n;
  logic          valid_i, ready_o, valid_o, ready_i;
  logic [DW-1:0] data_i, data_o;
`ifdef CDC_ASYNC_FIFO_LEVEL_EN
  logic [AW:0]   src_level, dest_level;
`endif

  cdc_async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHAIN_LENGTH(CL)) dut (
    .clk_src            (clk_src),
    .reset_master_src_n (reset_master_src_n),
    .clk_dest           (clk_dest),
    .reset_master_dest_n(reset_master_dest_n),
    .valid_i            (valid_i),
    .data_i             (data_i),
    .ready_o            (ready_o),
    .valid_o            (valid_o),
    .data_o             (data_o),
    .ready_i            (ready_i)
`ifdef CDC_ASYNC_FIFO_LEVEL_EN
    ,
    .src_level_o        (src_level),
    .dest_level_o       (dest_level)
`endif
  );

  int            n_checks = 0;
  int            n_pass = 0;
  int            popped = 0;
  logic [DW-1:0] last_pop = '0;
  logic          rand_ready = 1'b0;
  logic [DW-1:0] model_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: every accepted word is queued; every consumed word must be the queue head.
  always @(negedge clk_src) begin
    if (reset_master_src_n && valid_i && ready_o) begin
      chk("no_overflow", 64'(model_q.size() < DEPTH), 64'(1));
      model_q.push_back(data_i);
    end
  end

  always @(negedge clk_dest) begin
    if (reset_master_dest_n && valid_o && ready_i) begin
      if (model_q.size() == 0) chk("underflow", 64'(1), 64'(0));
      else begin
        last_pop = model_q.pop_front();
        chk("pop_data", 64'(data_o), 64'(last_pop));
        popped++;
      end
    end
  end

  always @(posedge clk_dest) begin
    if (rand_ready) begin
      #1 ready_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic align_src();
    @(posedge clk_src);
    #1;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk_dest);
    #1 ready_i = r;
  endtask

  // Offer one word; returns 1 ns after the clk_src edge that accepted it.
  task automatic send(input logic [DW-1:0] w);
    valid_i = 1'b1;
    data_i  = w;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_src);
      if (ready_o) begin
        @(posedge clk_src);
        #1 valid_i = 1'b0;
        return;
      end
    end
    chk("send_timeout", 64'(0), 64'(1));
    valid_i = 1'b0;
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_dest);
      if (model_q.size() == 0) break;
    end
    chk("drained", 64'(model_q.size()), 64'(0));
  endtask

  initial begin
    int k;
    int p0;
    reset_master_src_n  = 1'b0;
    reset_master_dest_n = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    ready_i = 1'b0;

    repeat (3) @(negedge clk_dest);
    chk("rst_ready", 64'(ready_o), 64'(0));
    chk("rst_valid", 64'(valid_o), 64'(0));
    @(negedge clk_src);
    reset_master_src_n  = 1'b1;
    reset_master_dest_n = 1'b1;
    @(negedge clk_src);
    chk("ready_after_rst", 64'(ready_o), 64'(1));

    // Single word: latency and first-word fall-through.
    align_src();
    send(32'h0000_1ced);
    for (k = 1; k < 20; k++) begin
      @(posedge clk_dest);
      #1;
      if (valid_o) break;
    end
    chk("wr2valid_latency_ok", 64'(k >= CL + 1 && k <= CL + 2), 64'(1));
    chk("single_data", 64'(data_o), 64'(32'h0000_1ced));
    ready_i = 1'b1;
    @(posedge clk_dest);
    #1 ready_i = 1'b0;
    chk("single_pop_empty", 64'(valid_o), 64'(0));

    // Fill to full with backpressure, then hold an extra word.
    p0 = popped;
    align_src();
    for (int i = 0; i < DEPTH; i++) send(DW'(i));
    chk("full_ready_low", 64'(ready_o), 64'(0));
    valid_i = 1'b1;
    data_i  = 32'hdead_beef;
    repeat (20) begin
      @(negedge clk_src);
      chk("full_hold", 64'(ready_o), 64'(0));
    end
    fork
      send(32'hdead_beef);
      set_ready(1'b1);
    join
    drain_wait();
    chk("fill_drain_count", 64'(popped - p0), 64'(DEPTH + 1));
    chk("fill_last_word", 64'(last_pop), 64'(32'hdead_beef));

    // Streams at both clock ratios, wrapping the pointers several times.
    for (int r = 0; r < 2; r++) begin
      p0 = popped;
      align_src();
      for (int i = 1; i <= 40; i++) send(DW'(i));
      drain_wait();
      chk("stream_count", 64'(popped - p0), 64'(40));
      chk("stream_last", 64'(last_pop), 64'(40));
      src_half  = 32;
      dest_half = 5;
      repeat (4) @(negedge clk_src);
    end

    // Occupancy with three words resident, then after one pop.
    set_ready(1'b0);
    align_src();
    for (int i = 0; i < 3; i++) send($urandom);
    repeat (10) @(negedge clk_dest);
    repeat (6) @(negedge clk_src);
    chk("three_valid", 64'(valid_o), 64'(1));
`ifdef CDC_ASYNC_FIFO_LEVEL_EN
    chk("src_level_3", 64'(src_level), 64'(3));
    chk("dest_level_3", 64'(dest_level), 64'(3));
`endif
    set_ready(1'b1);
    @(posedge clk_dest);
    #1 ready_i = 1'b0;
    repeat (6) @(negedge clk_src);
    repeat (10) @(negedge clk_dest);
    chk("two_left", 64'(model_q.size()), 64'(2));
`ifdef CDC_ASYNC_FIFO_LEVEL_EN
    chk("src_level_2", 64'(src_level), 64'(2));
    chk("dest_level_2", 64'(dest_level), 64'(2));
`endif

    // Random data, random gaps, random sink backpressure.
    src_half  = 5;
    dest_half = 7;
    rand_ready = 1'b1;
    p0 = popped;
    align_src();
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) align_src();
      send($urandom);
    end
    @(posedge clk_dest);
    rand_ready = 1'b0;
    #2 ready_i = 1'b1;
    drain_wait();
    chk("random_count", 64'(popped - p0), 64'(62));

    // Shared reset with words in flight.
    set_ready(1'b0);
    align_src();
    for (int i = 0; i < 5; i++) send(DW'(32'h100 + i));
    repeat (8) @(negedge clk_dest);
    chk("inflight_valid", 64'(valid_o), 64'(1));
    @(negedge clk_src);
    #2;
    reset_master_src_n  = 1'b0;
    reset_master_dest_n = 1'b0;
    model_q.delete();
    #1;
    chk("midrst_valid", 64'(valid_o), 64'(0));
    chk("midrst_ready", 64'(ready_o), 64'(0));
    repeat (3) @(negedge clk_dest);
    reset_master_src_n  = 1'b1;
    reset_master_dest_n = 1'b1;
    repeat (3) @(negedge clk_dest);
    chk("post_rst_empty", 64'(valid_o), 64'(0));
    p0 = popped;
    align_src();
    send(32'h00c0_ffee);
    set_ready(1'b1);
    drain_wait();
    chk("post_rst_count", 64'(popped - p0), 64'(1));
    chk("post_rst_first", 64'(last_pop), 64'(32'h00c0_ffee));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cdc_async_fifo.md
# cdc_async_fifo

Parametrised clock-domain-crossing FIFO that carries a stream of words from the clk_src domain to the clk_dest domain with valid/ready flow control on both sides. It replaces the single-word handshake synchronizer wherever the source must issue back-to-back words or the sink must apply backpressure. Each domain sits behind its own reset synchronizer, and both synchronizers are driven from one common board-level reset.

## Interface
- DATA_WIDTH, 32, payload width in bits.
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH entries; ADDR_WIDTH >= 1.
- CHAIN_LENGTH, 3, flops per pointer synchronizer; CHAIN_LENGTH >= 2.

Ports:
- clk_src  in  1  source clock.
- reset_master_src_n  in  1  reset, asynchronous, active-low, clk_src domain.
- clk_dest  in  1  destination clock.
- reset_master_dest_n  in  1  reset, asynchronous, active-low, clk_dest domain.
- valid_i  in  1  source word offered.
- data_i  in  DATA_WIDTH  source word.
- ready_o  out  1  FIFO accepts a word this clk_src edge.
- valid_o  out  1  destination word available.
- data_o  out  DATA_WIDTH  head-of-FIFO word, valid when valid_o = 1.
- ready_i  in  1  sink consumes the head word.
- src_level_o  out  ADDR_WIDTH+1  occupancy seen from clk_src. Present only with the macro.
- dest_level_o  out  ADDR_WIDTH+1  occupancy seen from clk_dest. Present only with the macro.

## Operation
- Write pointer and read pointer are each ADDR_WIDTH+1 bits, kept in both binary and Gray form and registered in their own domain.
- Only the Gray forms cross domains, each through a CHAIN_LENGTH-flop chain clocked by the receiving domain.
- Storage is a DEPTH x DATA_WIDTH register array.
  - Written on clk_src.
  - Read asynchronously at the read address, so the FIFO is first-word-fall-through.
- Write: on a clk_src rising edge with valid_i & ready_o, mem[wptr[ADDR_WIDTH-1:0]] <= data_i and wptr increments.
  - valid_i with ready_o = 0 is ignored; the source holds the word.
- Read: on a clk_dest rising edge with valid_o & ready_i, rptr increments.
  - ready_i with valid_o = 0 is ignored.
- Full: the next Gray write pointer equals the synchronized Gray read pointer with its two MSBs inverted. ready_o <= ~full_next, registered.
- Empty: the next Gray read pointer equals the synchronized Gray write pointer. valid_o <= ~empty_next, registered.
- Wrap-around: pointers wrap naturally at 2**(ADDR_WIDTH+1). The extra MSB distinguishes full from empty.
- Flags are conservative:
  - ready_o may stay low after space frees; valid_o may stay low after data arrives.
  - The FIFO never overflows, underflows, drops or duplicates a word.

## Timing
- In reset:
  - src domain: ready_o = 0, wptr = 0, src-side sync chain = 0.
  - dest domain: valid_o = 0, rptr = 0, dest-side sync chain = 0.
  - data_o is don't-care.
- ready_o rises on the first clk_src edge after reset_master_src_n deasserts.
- Write-to-valid latency: valid_o rises CHAIN_LENGTH+1 to CHAIN_LENGTH+2 clk_dest rising edges after the writing clk_src edge.
- Read-to-ready latency: ready_o rises CHAIN_LENGTH+1 to CHAIN_LENGTH+2 clk_src rising edges after a read frees a slot in a full FIFO.
- Throughput:
  - One word per clk_src cycle while not full.
  - One word per clk_dest cycle while not empty.
- Simultaneous write and read in the same instant: both complete; no ordering dependence.
- Reset mid-operation: both resets must assert together, which is guaranteed by the shared reset source. All contents are discarded and the FIFO is empty after release.
  - Resetting only one domain is unsupported.
  - With the macro defined, a simulation assertion flags it.

## Configuration
- CDC_ASYNC_FIFO_LEVEL_EN defined:
  - Instantiates Gray-to-binary conversion of both synchronized pointers.
  - src_level_o = wptr - sync(rptr). Registered; may overestimate; never exceeds DEPTH.
  - dest_level_o = sync(wptr) - rptr. Registered; may underestimate; never exceeds DEPTH.
  - Adds the one-sided-reset simulation assertion.
- CDC_ASYNC_FIFO_LEVEL_EN undefined:
  - Level ports and conversion logic are absent.
  - Flag behaviour is identical.

## Structure
- Package cdc_pkg holds:
  - bin2gray and gray2bin functions, parametrised by width.
  - The minimum-CHAIN_LENGTH constant, set to 2.
- One sub-module, cdc_gray_sync: a WIDTH-bit, CHAIN_LENGTH-deep flop chain with its own clock and async active-low reset.
  - Instantiated once per direction.

## Test plan
- Reset (clk_src 10 ns, clk_dest 64 ns):
  - During reset, ready_o = 0 and valid_o = 0.
  - ready_o = 1 one clk_src edge after release.
- Single word 0x00001ced written:
  - valid_o = 1 within CHAIN_LENGTH+2 dest edges, with data_o = 0x00001ced.
  - ready_i = 1 pops it; valid_o = 0 on the next dest edge.
- Fill with ready_i = 0, words 0..7, ADDR_WIDTH = 3:
  - ready_o = 0 after the 8th write.
  - 0xdeadbeef is held and not written.
  - Drain yields 0..7 in order, then 0xdeadbeef.
- Stream words 1..40 with ready_i = 1 and both clock ratios (10/64 ns, then 64/10 ns):
  - Exact sequence out, no loss or duplication, pointer wrap exercised.
- Macro defined:
  - 3 writes then idle 10 dest cycles: src_level_o = 3, dest_level_o = 3.
  - After 1 pop and settling: both = 2.
- Shared reset asserted with 5 words in flight:
  - valid_o = 0 and ready_o = 0 immediately.
  - After release, the FIFO is empty and the next written word 0x00c0ffee emerges first.
